// File: rtl/fetch_if.sv
// fetch_if: instruction-memory port, redirect and decode handshake of the fetch stage.
interface fetch_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    modport master (
        output imem_addr, out_valid, out_instr, out_pc,
        input  imem_rdata, redirect_valid, redirect_pc, out_ready
    );
    modport slave (
        input  imem_addr, out_valid, out_instr, out_pc,
        output imem_rdata, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC holder issuing one word fetch per step_en into a 1-cycle instr_mem,
// presenting {instr, pc} to decode over valid/ready with redirect squash.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        step_en,
    output logic [15:0] fetch_count,
    fetch_if.master     bus
);
    localparam logic [31:0] ADDR_MASK = 32'(IMEM_WORDS * 4 - 4);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, issued_pc_q, issued_pc_d;
    logic [31:0] out_instr_q, out_instr_d, out_pc_q, out_pc_d;
    logic        out_valid_q, out_valid_d;
    logic [15:0] count_q, count_d;
    logic        slot_free, handshake;

    assign slot_free     = !out_valid_q || bus.out_ready;
    assign handshake     = out_valid_q && bus.out_ready;
    assign bus.imem_addr = pc_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = out_instr_q;
    assign bus.out_pc    = out_pc_q;
    assign fetch_count   = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC & ADDR_MASK;
            issued_pc_q <= '0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
            out_valid_q <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            issued_pc_q <= issued_pc_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
            out_valid_q <= out_valid_d;
            count_q     <= count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        issued_pc_d = issued_pc_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        out_valid_d = handshake ? 1'b0 : out_valid_q;
        count_d     = (handshake && count_q != 16'hFFFF) ? count_q + 16'd1 : count_q;
        // Redirect wins over capture and issue; a coincident handshake is still counted.
        if (bus.redirect_valid) begin
            pc_d        = bus.redirect_pc & ADDR_MASK;
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
        end else if (state_q == S_WAIT) begin
            out_instr_d = bus.imem_rdata;
            out_pc_d    = issued_pc_q;
            out_valid_d = 1'b1;
            state_d     = S_IDLE;
        end else if (step_en && slot_free) begin
            issued_pc_d = pc_q;
            pc_d        = (pc_q + 32'd4) & ADDR_MASK;
            state_d     = S_WAIT;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed timing steps plus randomized traffic checked against a
// transaction-level model of the expected instruction stream.
module tb_fetch_stage;
    localparam int          WORDS = 16;
    localparam logic [31:0] AMASK = 32'(WORDS * 4 - 4);

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        step_en = 1'b0;
    logic [15:0] fetch_count;
    logic [31:0] mem [WORDS];
    int          errors = 0;
    int          checks = 0;

    fetch_if bus();

    fetch_stage #(.RESET_PC(32'h0), .IMEM_WORDS(WORDS)) dut (
        .clk(clk), .reset(reset), .step_en(step_en), .fetch_count(fetch_count), .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.imem_rdata <= mem[bus.imem_addr[5:2]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Model: the stream handed to decode is consecutive wrapped PCs, restarted by redirect/reset.
    logic        armed = 1'b0, stall = 1'b0;
    logic [31:0] exp_pc = 32'h0, prev_pc, prev_instr;
    int          hs_cnt = 0;

    always @(negedge clk) begin
        if (armed) begin
            check("count", 32'(fetch_count), 32'(hs_cnt));
            check("addr_range", bus.imem_addr & ~AMASK, 32'h0);
            if (stall) begin
                check("stall_valid", 32'(bus.out_valid), 32'h1);
                check("stall_pc", bus.out_pc, prev_pc);
                check("stall_instr", bus.out_instr, prev_instr);
            end
            if (!reset && bus.out_valid && bus.out_ready) begin
                check("hs_pc", bus.out_pc, exp_pc);
                check("hs_instr", bus.out_instr, mem[exp_pc[5:2]]);
                exp_pc = (exp_pc + 32'd4) & AMASK;
                if (hs_cnt < 16'hFFFF) hs_cnt++;
            end
            if (!reset && bus.redirect_valid) exp_pc = bus.redirect_pc & AMASK;
        end
        if (reset) begin
            armed  = 1'b1;
            exp_pc = 32'h0;
            hs_cnt = 0;
            stall  = 1'b0;
        end else begin
            stall = bus.out_valid && !bus.out_ready && !bus.redirect_valid;
        end
        prev_pc    = bus.out_pc;
        prev_instr = bus.out_instr;
    end

    initial begin
        for (int i = 0; i < WORDS; i++) mem[i] = 32'hA000_0000 + i;
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        step_en            = 1'b1;
        tick(3);
        check("rst_valid", 32'(bus.out_valid), 32'h0);
        check("rst_count", 32'(fetch_count), 32'h0);
        check("rst_addr", bus.imem_addr, 32'h0);
        check("rst_out_pc", bus.out_pc, 32'h0);
        check("rst_out_instr", bus.out_instr, 32'h0);
        // Stream from reset: valid two cycles after release, one word every two cycles.
        reset = 1'b0;
        check("lat_c0", 32'(bus.out_valid), 32'h0);
        tick(1);
        check("lat_c1", 32'(bus.out_valid), 32'h0);
        tick(1);
        check("lat_c2", 32'(bus.out_valid), 32'h1);
        check("first_pc", bus.out_pc, 32'h0);
        check("first_instr", bus.out_instr, 32'hA000_0000);
        tick(1);
        check("gap", 32'(bus.out_valid), 32'h0);
        tick(1);
        check("second_pc", bus.out_pc, 32'h4);
        check("second_instr", bus.out_instr, 32'hA000_0001);
        tick(28);
        check("last_pc", bus.out_pc, 32'h3C);
        tick(2);
        check("wrap_pc", bus.out_pc, 32'h0);
        check("wrap_instr", bus.out_instr, 32'hA000_0000);
        check("wrap_count", 32'(fetch_count), 32'd16);
        tick(2);
        check("w18_pc", bus.out_pc, 32'h4);
        check("w18_count", 32'(fetch_count), 32'd17);
        // Backpressure: word held, no issue.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", 32'(bus.out_valid), 32'h1);
            check("bp_pc", bus.out_pc, 32'h4);
            check("bp_addr", bus.imem_addr, 32'h8);
            check("bp_count", 32'(fetch_count), 32'd17);
            tick(1);
        end
        bus.out_ready = 1'b1;
        tick(1);
        check("rel_gap", 32'(bus.out_valid), 32'h0);
        tick(1);
        check("rel_pc", bus.out_pc, 32'h8);
        check("rel_instr", bus.out_instr, 32'hA000_0002);
        check("rel_count", 32'(fetch_count), 32'd18);
        // Redirect while the fetch of 0xC is in flight.
        tick(1);
        check("rd_inflight", 32'(bus.out_valid), 32'h0);
        check("rd_addr_pre", bus.imem_addr, 32'h10);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h23;
        tick(1);
        bus.redirect_valid = 1'b0;
        check("rd_squash", 32'(bus.out_valid), 32'h0);
        check("rd_addr", bus.imem_addr, 32'h20);
        check("rd_count", 32'(fetch_count), 32'd19);
        tick(1);
        check("rd_gap", 32'(bus.out_valid), 32'h0);
        tick(1);
        check("rd_valid", 32'(bus.out_valid), 32'h1);
        check("rd_pc", bus.out_pc, 32'h20);
        check("rd_instr", bus.out_instr, 32'hA000_0008);
        // Pulsed step_en: one word per pulse.
        step_en = 1'b0;
        tick(2);
        check("pulse_idle", 32'(bus.out_valid), 32'h0);
        for (int p = 0; p < 4; p++) begin
            step_en = 1'b1;
            tick(1);
            step_en = 1'b0;
            check("pulse_wait", 32'(bus.out_valid), 32'h0);
            tick(1);
            check("pulse_valid", 32'(bus.out_valid), 32'h1);
            check("pulse_pc", bus.out_pc, 32'h24 + 32'(4 * p));
            tick(6);
        end
        check("pulse_count", 32'(fetch_count), 32'd24);
        step_en = 1'b1;
        tick(2);
        step_en = 1'b0;
        check("drop_valid", 32'(bus.out_valid), 32'h1);
        check("drop_pc", bus.out_pc, 32'h34);
        tick(1);
        check("drop_gap1", 32'(bus.out_valid), 32'h0);
        tick(1);
        check("drop_gap2", 32'(bus.out_valid), 32'h0);
        tick(1);
        check("drop_count", 32'(fetch_count), 32'd25);
        check("drop_addr", bus.imem_addr, 32'h38);
        // Reset with a held word, then reset with a fetch in flight.
        step_en       = 1'b1;
        bus.out_ready = 1'b0;
        tick(2);
        check("pre_rst_valid", 32'(bus.out_valid), 32'h1);
        check("pre_rst_pc", bus.out_pc, 32'h38);
        reset = 1'b1;
        tick(1);
        check("rst2_valid", 32'(bus.out_valid), 32'h0);
        check("rst2_count", 32'(fetch_count), 32'h0);
        check("rst2_addr", bus.imem_addr, 32'h0);
        reset         = 1'b0;
        bus.out_ready = 1'b1;
        tick(1);
        reset = 1'b1;
        tick(1);
        check("rst3_valid", 32'(bus.out_valid), 32'h0);
        check("rst3_addr", bus.imem_addr, 32'h0);
        reset   = 1'b0;
        step_en = 1'b0;
        tick(1);
        check("rst3_discard", 32'(bus.out_valid), 32'h0);
        check("rst3_count", 32'(fetch_count), 32'h0);
        // Randomized traffic against the stream model.
        reset = 1'b1;
        for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
        tick(2);
        reset = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            step_en            = ($urandom_range(0, 2) != 0);
            bus.out_ready      = ($urandom_range(0, 9) < 7);
            bus.redirect_valid = ($urandom_range(0, 11) == 0);
            bus.redirect_pc    = $urandom;
            reset              = ($urandom_range(0, 299) == 0);
            tick(1);
        end
        reset              = 1'b0;
        step_en            = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.out_ready      = 1'b1;
        tick(4);
        check("drain_valid", 32'(bus.out_valid), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
